// File: rtl/ones_frame_collector_if.sv
// Serial-in / parallel-out handshake bundle for the ones frame collector.
// The slave side is the collector; the master side feeds bits and consumes frames.
interface ones_frame_collector_if;
    logic        sin;
    logic        sin_valid;
    logic        sof;
    logic        sin_ready;
    logic [14:0] word;
    logic [3:0]  ones;
    logic        word_valid;
    logic        word_ready;
    logic        frame_err;

    modport master (
        output sin,
        output sin_valid,
        output sof,
        output word_ready,
        input  sin_ready,
        input  word,
        input  ones,
        input  word_valid,
        input  frame_err
    );

    modport slave (
        input  sin,
        input  sin_valid,
        input  sof,
        input  word_ready,
        output sin_ready,
        output word,
        output ones,
        output word_valid,
        output frame_err
    );
endinterface

// File: rtl/ones_frame_collector.sv
// Assembles a serial bit stream into 15-bit frames with a running ones tally,
// and hands each frame downstream over a valid/ready handshake.
module ones_frame_collector #(
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                    clk,
    input  logic                    rstn,
    ones_frame_collector_if.slave   bus
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FILL  = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t      state_r;
    state_t      state_nxt_s;
    logic [3:0]  cnt_r;
    logic [3:0]  cnt_nxt_s;
    logic [14:0] shift_r;
    logic [14:0] shift_nxt_s;
    logic [3:0]  run_r;
    logic [3:0]  run_nxt_s;
    logic [14:0] word_r;
    logic [3:0]  ones_r;
    logic        word_valid_r;
    logic        frame_err_r;
    logic        err_nxt_s;
    logic        load_word_s;
    logic        sin_ready_s;
    logic        accept_s;
    logic        take_s;
    logic [14:0] first_shift_s;
    logic [14:0] append_shift_s;
    logic [3:0]  first_run_s;
    logic [3:0]  append_run_s;

    // Insert one serial bit; the first bit of a frame migrates to bit 14 (MSB-first) or bit 0.
    function automatic logic [14:0] shift_in(input logic [14:0] cur, input logic b);
        logic [14:0] res;
        if (MSB_FIRST) begin
            res = {cur[13:0], b};
        end else begin
            res = {b, cur[14:1]};
        end
        return res;
    endfunction

    // Add one serial bit to the 4-bit tally; at most 15 bits per frame so it cannot wrap.
    function automatic logic [3:0] tally_add(input logic [3:0] cur, input logic b);
        return cur + {3'b000, b};
    endfunction

    // Ready drops only while a finished frame is waiting and downstream is not taking it.
    always_comb begin
        sin_ready_s    = (state_r != ST_FULL) | bus.word_ready;
        accept_s       = bus.sin_valid & sin_ready_s;
        take_s         = word_valid_r & bus.word_ready;
        first_shift_s  = shift_in(15'h0000, bus.sin);
        append_shift_s = shift_in(shift_r, bus.sin);
        first_run_s    = {3'b000, bus.sin};
        append_run_s   = tally_add(run_r, bus.sin);
    end

    // Next-state and datapath update for the frame assembly FSM.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        shift_nxt_s = shift_r;
        run_nxt_s   = run_r;
        err_nxt_s   = 1'b0;
        load_word_s = 1'b0;
        case (state_r)
            ST_EMPTY: begin
                if (accept_s) begin
                    shift_nxt_s = first_shift_s;
                    cnt_nxt_s   = 4'd1;
                    run_nxt_s   = first_run_s;
                    state_nxt_s = ST_FILL;
                end else begin
                    state_nxt_s = ST_EMPTY;
                end
            end
            ST_FILL: begin
                if (accept_s) begin
                    if (bus.sof) begin
                        // A new frame started before this one finished: restart on this bit.
                        shift_nxt_s = first_shift_s;
                        cnt_nxt_s   = 4'd1;
                        run_nxt_s   = first_run_s;
                        err_nxt_s   = 1'b1;
                        state_nxt_s = ST_FILL;
                    end else if (cnt_r == 4'd14) begin
                        load_word_s = 1'b1;
                        shift_nxt_s = 15'h0000;
                        cnt_nxt_s   = 4'd0;
                        run_nxt_s   = 4'd0;
                        state_nxt_s = ST_FULL;
                    end else begin
                        shift_nxt_s = append_shift_s;
                        cnt_nxt_s   = cnt_r + 4'd1;
                        run_nxt_s   = append_run_s;
                        state_nxt_s = ST_FILL;
                    end
                end else begin
                    state_nxt_s = ST_FILL;
                end
            end
            ST_FULL: begin
                if (take_s) begin
                    if (accept_s) begin
                        shift_nxt_s = first_shift_s;
                        cnt_nxt_s   = 4'd1;
                        run_nxt_s   = first_run_s;
                        state_nxt_s = ST_FILL;
                    end else begin
                        cnt_nxt_s   = 4'd0;
                        run_nxt_s   = 4'd0;
                        state_nxt_s = ST_EMPTY;
                    end
                end else begin
                    state_nxt_s = ST_FULL;
                end
            end
            default: begin
                shift_nxt_s = 15'h0000;
                cnt_nxt_s   = 4'd0;
                run_nxt_s   = 4'd0;
                state_nxt_s = ST_EMPTY;
            end
        endcase
    end

    // State, assembly registers and registered outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r      <= ST_EMPTY;
            cnt_r        <= 4'd0;
            shift_r      <= 15'h0000;
            run_r        <= 4'd0;
            word_r       <= 15'h0000;
            ones_r       <= 4'd0;
            word_valid_r <= 1'b0;
            frame_err_r  <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            cnt_r        <= cnt_nxt_s;
            shift_r      <= shift_nxt_s;
            run_r        <= run_nxt_s;
            word_valid_r <= (state_nxt_s == ST_FULL);
            frame_err_r  <= err_nxt_s;
            // word/ones change only when a frame completes and hold through the take.
            if (load_word_s) begin
                word_r <= append_shift_s;
                ones_r <= append_run_s;
            end else begin
                word_r <= word_r;
                ones_r <= ones_r;
            end
        end
    end

    assign bus.sin_ready  = sin_ready_s;
    assign bus.word       = word_r;
    assign bus.ones       = ones_r;
    assign bus.word_valid = word_valid_r;
    assign bus.frame_err  = frame_err_r;

endmodule

// File: doc/ones_frame_collector.md
# ones_frame_collector

Serial-to-parallel front end for the 15-bit ones-counter datapath. It assembles a serial bit stream into 15-bit frames and presents each frame with a valid/ready handshake to the 15-bit ones counter downstream. Alongside each word it delivers a registered 4-bit ones tally, accumulated bit by bit, which verification and downstream logic use to cross-check the combinational count.

## Interface
Parameters:
- MSB_FIRST, default 1: 1 = first serial bit lands in word[14]; 0 = first serial bit lands in word[0].

Ports:
- clk  in  1  single clock, rising-edge.
- rstn  in  1  reset, asynchronous, active-low. One clock; reset is asynchronous and active-low.
- sin  in  1  serial data bit.
- sin_valid  in  1  sin is valid this cycle.
- sof  in  1  start-of-frame marker, qualified by sin_valid.
- sin_ready  out  1  collector can accept a bit this cycle (combinational).
- word  out  15  assembled frame; stable while word_valid=1.
- ones  out  4  number of 1s in word; valid with word_valid.
- word_valid  out  1  frame available.
- word_ready  in  1  downstream consumes frame.
- frame_err  out  1  one-cycle pulse: partial frame discarded by sof.

## Operation
- accept = sin_valid & sin_ready. take = word_valid & word_ready.
- sin_ready = (state != FULL) | word_ready.
- Internal: 4-bit bit counter cnt (0..15), 15-bit shift register, 4-bit running tally run.
- States:
  - EMPTY: cnt=0. accept -> load bit, cnt=1, run=sin -> FILL.
  - FILL: cnt 1..14. accept, sof=0 -> shift bit in, cnt+1, run+sin; if new cnt=15 -> FULL, word/ones registered from shift reg/run, word_valid=1.
  - FILL, accept with sof=1 -> partial discarded, bit loaded as first bit of new frame, cnt=1, run=sin, frame_err=1 for one cycle, stay FILL.
  - FULL: word, ones, word_valid held. take & accept -> new bit loaded as first bit, cnt=1 -> FILL. take only -> EMPTY, word_valid=0. Neither -> hold.
- sof with cnt=0 (EMPTY or FULL handshake cycle) is legal, no error. sof=1 without sin_valid is ignored.
- Bit order: MSB_FIRST=1 shifts left (new bit into bit 0, first bit ends in bit 14); MSB_FIRST=0 shifts right (new bit into bit 14, first bit ends in bit 0).
- Tally arithmetic: 4-bit unsigned, max 15, never wraps inside a frame.
- word and ones change only on the edge that enters FULL; they keep their last value after take, until the next frame completes.

## Timing
- Reset (rstn=0, asynchronous): state EMPTY, cnt=0, run=0, word=15'h0000, ones=4'h0, word_valid=0, frame_err=0. sin_ready=1. Release is synchronous to the first following clk edge.
- Reset mid-frame: partial bits lost. Reset while FULL: the pending word is dropped.
- Latency: the 15th bit is accepted at edge k. word_valid=1 and the new word/ones are visible after edge k.
- Throughput: 1 bit/clk. With word_ready held 1 and sin_valid continuous, one frame per 15 cycles with no bubble. word_valid is high for exactly one cycle per frame.
- Backpressure: in FULL with word_ready=0, sin_ready=0 and no bit is accepted or lost. When word_ready rises, sin_ready rises combinationally the same cycle.
- frame_err asserts the cycle after the offending accept edge and clears on the next edge.

## Test plan
- Reset then MSB-first stream 1,0,1,0,…,1 (15 bits), word_ready=1 -> one-cycle word_valid, word=15'h5555, ones=8, frame_err=0.
- Two back-to-back frames: all-ones, then all-zeros, sin_valid continuous, word_ready=1 -> word=15'h7FFF/ones=15 at cycle 15, word=15'h0000/ones=0 at cycle 30, sin_ready always 1.
- Backpressure: frame 15'h0001 completes, word_ready=0 for 5 cycles while sin_valid=1 -> sin_ready=0, word stable 15'h0001, ones=1. Raise word_ready -> bit accepted that cycle as bit 1 of the next frame.
- sof mid-frame: 5 bits of 1, then sof=1 with 15 bits of 15'h4000 (MSB-first) -> frame_err pulses once after the 6th accept; next word=15'h4000, ones=1.
- Asynchronous reset after 7 accepted bits (asserted between edges) -> all outputs 0 immediately. Next 15 bits 15'h7FFE -> word=15'h7FFE, ones=14.
- MSB_FIRST=0 instance, stream 1 followed by 14 zeros -> word=15'h0001, ones=1.
